// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one 32-bit word per line.
// Optional hit/miss/write counters are enabled by defining DATA_CACHE_STATS_EN.
module data_cache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] write_count
`endif
);

    // state   | meaning
    // IDLE    | accept core requests; load hits complete here
    // RD_WAIT | refill read outstanding on backing memory
    // WR_WAIT | write-through outstanding on backing memory
    // DONE    | one stall-free cycle completing a miss or store
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 32 - INDEX_BITS;

    state_t                  state;
    logic [31:0]             req_addr;
    logic [31:0]             req_wd;
    logic [31:0]             resp;
    logic [LINES-1:0]        valid;
    logic [31:0]             data_mem [LINES];
    logic [TAG_W-1:0]        tag_mem  [LINES];

    logic [INDEX_BITS-1:0]   idx;
    logic [INDEX_BITS-1:0]   req_idx;
    logic                    hit;
    logic                    req_hit;
    logic                    load_hit;
    logic                    rd_done;
    logic                    wr_done;

    assign idx      = addr[INDEX_BITS-1:0];
    assign req_idx  = req_addr[INDEX_BITS-1:0];
    assign hit      = valid[idx] && (tag_mem[idx] == addr[31:INDEX_BITS]);
    assign req_hit  = valid[req_idx] && (tag_mem[req_idx] == req_addr[31:INDEX_BITS]);
    assign load_hit = (state == IDLE) && en && !we && hit;
    assign rd_done  = (state == RD_WAIT) && mem_ack;
    assign wr_done  = (state == WR_WAIT) && mem_ack;

    assign mem_req   = (state == RD_WAIT) || (state == WR_WAIT);
    assign mem_we    = (state == WR_WAIT);
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wd;
    assign rd        = (state == DONE) ? resp : data_mem[idx];

    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = en && (we || !hit);
            RD_WAIT: stall = 1'b1;
            WR_WAIT: stall = 1'b1;
            DONE:    stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            valid    <= '0;
            resp     <= '0;
            req_addr <= '0;
            req_wd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        req_addr <= addr;
                        req_wd   <= wd;
                        if (we)
                            state <= WR_WAIT;
                        else if (!hit)
                            state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_ack) begin
                        valid[req_idx] <= 1'b1;
                        resp           <= mem_rdata;
                        state          <= DONE;
                    end
                end
                WR_WAIT: begin
                    if (mem_ack)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Arrays carry no reset; an ack coinciding with reset is dropped with the transaction.
    always_ff @(posedge clock) begin
        if (!reset && rd_done) begin
            data_mem[req_idx] <= mem_rdata;
            tag_mem[req_idx]  <= req_addr[31:INDEX_BITS];
        end else if (!reset && wr_done && req_hit) begin
            data_mem[req_idx] <= req_wd;
        end
    end

`ifdef DATA_CACHE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count   <= '0;
            miss_count  <= '0;
            write_count <= '0;
        end else begin
            if (load_hit)
                hit_count <= hit_count + 32'd1;
            if (rd_done)
                miss_count <= miss_count + 32'd1;
            if (wr_done)
                write_count <= write_count + 32'd1;
        end
    end
`endif

endmodule
